// File: rtl/boot_stream_loader.sv
// Streams ROM_LEN boot bytes from a ROM into the core download port, then pulses execute_enable.
// Optional BOOT_CHECKSUM_EN: verify the modulo-256 byte sum against CHECKSUM before starting the CPU.
module boot_stream_loader #(
    parameter int unsigned ROM_LEN   = 276,
    parameter logic [15:0] EXEC_ADDR = 16'h0000,
    parameter logic [7:0]  CHECKSUM  = 8'h00
) (
    input  logic        clk_sys,
    input  logic        reset,
    output logic [15:0] rom_addr,
    input  logic [7:0]  rom_data,
    input  logic        dn_wait,
    output logic        dn_go,
    output logic        dn_wr,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic [15:0] execute_addr,
    output logic        execute_enable,
    output logic        load_err
);

    typedef enum logic [1:0] {StIdle, StFetch, StWrite, StDone} state_e;

    localparam logic [15:0] LastAddr = 16'(ROM_LEN - 1);

    state_e      state;
    logic        accept;
    logic        last_byte;
    logic        checksum_ok;
    logic [15:0] next_addr;

    assign execute_addr = EXEC_ADDR;
    assign accept       = (state == StWrite) && !dn_wait;
    assign last_byte    = (dn_addr >= LastAddr);
    assign next_addr    = 16'(dn_addr + 16'd1);

`ifdef BOOT_CHECKSUM_EN
    logic [7:0] sum;
    logic [7:0] sum_with_byte;
    logic       err;

    // Include the byte being accepted so the verdict is ready on the DONE entry edge.
    assign sum_with_byte = 8'(sum + dn_data);
    assign checksum_ok   = (sum_with_byte == CHECKSUM);
    assign load_err      = err;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sum <= 8'h00;
            err <= 1'b0;
        end else if (accept) begin
            sum <= sum_with_byte;
            if (last_byte && !checksum_ok) begin
                err <= 1'b1;
            end
        end
    end
`else
    logic unused_checksum;

    assign unused_checksum = ^CHECKSUM;
    assign checksum_ok     = 1'b1;
    assign load_err        = 1'b0;
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state          <= StIdle;
            rom_addr       <= 16'h0000;
            dn_go          <= 1'b0;
            dn_wr          <= 1'b0;
            dn_addr        <= 16'h0000;
            dn_data        <= 8'h00;
            execute_enable <= 1'b0;
        end else begin
            execute_enable <= 1'b0;
            case (state)
                StIdle: begin
                    state    <= StFetch;
                    dn_go    <= 1'b1;
                    dn_addr  <= 16'h0000;
                    rom_addr <= 16'h0000;
                end
                StFetch: begin
                    state   <= StWrite;
                    dn_wr   <= 1'b1;
                    dn_data <= rom_data;
                end
                StWrite: begin
                    // Strobe, address and data stay frozen while the core stalls.
                    if (accept) begin
                        dn_wr   <= 1'b0;
                        dn_addr <= next_addr;
                        if (!last_byte) begin
                            state    <= StFetch;
                            rom_addr <= next_addr;
                        end else begin
                            state          <= StDone;
                            dn_go          <= 1'b0;
                            execute_enable <= checksum_ok;
                        end
                    end
                end
                StDone: begin
                    state <= StDone;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boot_stream_loader.sv
// Bench for boot_stream_loader: two instances (4-byte and 1-byte ROM) checked every cycle against
// a byte-level model, plus literal cycle expectations and randomized back-pressure and resets.
module tb_boot_stream_loader;

`ifdef BOOT_CHECKSUM_EN
    localparam bit CkEn = 1'b1;
`else
    localparam bit CkEn = 1'b0;
`endif

    localparam logic [15:0] Exec0 = 16'h1234;
    localparam logic [15:0] Exec1 = 16'hBEEF;
    localparam logic [7:0]  Cks0  = 8'hAA;
    localparam logic [7:0]  Cks1  = 8'h00;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        dn_wait = 1'b0;

    logic [15:0] rom_addr_a [2];
    logic [7:0]  rom_data_a [2];
    logic        dn_go_a [2];
    logic        dn_wr_a [2];
    logic [15:0] dn_addr_a [2];
    logic [7:0]  dn_data_a [2];
    logic [15:0] exec_addr_a [2];
    logic        exec_en_a [2];
    logic        load_err_a [2];

    logic [7:0]  rom [2][4];
    int          len [2] = '{4, 1};
    logic [7:0]  cks [2] = '{Cks0, Cks1};
    logic [15:0] exec_exp [2] = '{Exec0, Exec1};

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always #5 clk_sys = ~clk_sys;

    assign rom_data_a[0] = rom[0][rom_addr_a[0][1:0]];
    assign rom_data_a[1] = (rom_addr_a[1] == 16'h0000) ? rom[1][0] : 8'hEE;

    boot_stream_loader #(
        .ROM_LEN   (4),
        .EXEC_ADDR (Exec0),
        .CHECKSUM  (Cks0)
    ) u_dut0 (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .rom_addr       (rom_addr_a[0]),
        .rom_data       (rom_data_a[0]),
        .dn_wait        (dn_wait),
        .dn_go          (dn_go_a[0]),
        .dn_wr          (dn_wr_a[0]),
        .dn_addr        (dn_addr_a[0]),
        .dn_data        (dn_data_a[0]),
        .execute_addr   (exec_addr_a[0]),
        .execute_enable (exec_en_a[0]),
        .load_err       (load_err_a[0])
    );

    boot_stream_loader #(
        .ROM_LEN   (1),
        .EXEC_ADDR (Exec1),
        .CHECKSUM  (Cks1)
    ) u_dut1 (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .rom_addr       (rom_addr_a[1]),
        .rom_data       (rom_data_a[1]),
        .dn_wait        (dn_wait),
        .dn_go          (dn_go_a[1]),
        .dn_wr          (dn_wr_a[1]),
        .dn_addr        (dn_addr_a[1]),
        .dn_data        (dn_data_a[1]),
        .execute_addr   (exec_addr_a[1]),
        .execute_enable (exec_en_a[1]),
        .load_err       (load_err_a[1])
    );

    task automatic chk(input string name, input int inst, input logic [15:0] act,
                       input logic [15:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s[%0d] cycle %0d t=%0t: got %h, want %h", name, inst, cyc, $time,
                     act, exp);
        end
    endtask

    // Byte-level reference: which byte is in flight, whether it is being offered, load finished.
    bit         m_valid = 1'b0;
    bit         m_rst [2];
    bit         m_active [2];
    bit         m_offer [2];
    bit         m_fin [2];
    bit         m_pulse [2];
    bit         m_err [2];
    int         m_idx [2];
    logic [7:0] m_data [2];
    logic [7:0] m_sum [2];

    always @(posedge clk_sys) begin
        cyc     <= reset ? 0 : cyc + 1;
        m_valid <= m_valid | reset;
        for (int i = 0; i < 2; i++) begin
            m_pulse[i] <= 1'b0;
            m_rst[i]   <= reset;
            if (reset) begin
                m_active[i] <= 1'b0;
                m_offer[i]  <= 1'b0;
                m_fin[i]    <= 1'b0;
                m_err[i]    <= 1'b0;
                m_idx[i]    <= 0;
                m_data[i]   <= 8'h00;
                m_sum[i]    <= 8'h00;
            end else if (!m_active[i] && !m_fin[i]) begin
                m_active[i] <= 1'b1;
                m_offer[i]  <= 1'b0;
                m_idx[i]    <= 0;
            end else if (m_active[i] && !m_offer[i]) begin
                m_offer[i] <= 1'b1;
                m_data[i]  <= rom[i][m_idx[i]];
            end else if (m_active[i] && !dn_wait) begin
                m_offer[i] <= 1'b0;
                m_sum[i]   <= 8'(m_sum[i] + m_data[i]);
                if (m_idx[i] == len[i] - 1) begin
                    m_active[i] <= 1'b0;
                    m_fin[i]    <= 1'b1;
                    m_pulse[i]  <= !CkEn || (8'(m_sum[i] + m_data[i]) == cks[i]);
                    m_err[i]    <= CkEn && (8'(m_sum[i] + m_data[i]) != cks[i]);
                end else begin
                    m_idx[i] <= m_idx[i] + 1;
                end
            end
        end
    end

    always @(negedge clk_sys) begin
        if (m_valid) begin
            for (int i = 0; i < 2; i++) begin
                chk("dn_go", i, 16'(dn_go_a[i]), 16'(m_active[i]));
                chk("dn_wr", i, 16'(dn_wr_a[i]), 16'(m_active[i] && m_offer[i]));
                chk("execute_enable", i, 16'(exec_en_a[i]), 16'(m_pulse[i]));
                chk("load_err", i, 16'(load_err_a[i]), 16'(m_err[i]));
                chk("execute_addr", i, exec_addr_a[i], exec_exp[i]);
                if (m_rst[i]) begin
                    chk("rst_rom_addr", i, rom_addr_a[i], 16'h0000);
                    chk("rst_dn_addr", i, dn_addr_a[i], 16'h0000);
                    chk("rst_dn_data", i, 16'(dn_data_a[i]), 16'h0000);
                end else if (m_active[i] && m_offer[i]) begin
                    chk("dn_addr", i, dn_addr_a[i], 16'(m_idx[i]));
                    chk("dn_data", i, 16'(dn_data_a[i]), 16'(m_data[i]));
                end else if (m_active[i]) begin
                    chk("fetch_rom_addr", i, rom_addr_a[i], 16'(m_idx[i]));
                    chk("fetch_dn_addr", i, dn_addr_a[i], 16'(m_idx[i]));
                end
            end
        end
    end

    task automatic wait_cycle(input int k);
        int guard = 0;
        while (cyc != k && guard < 1000) begin
            @(negedge clk_sys);
            guard++;
        end
        if (cyc != k) begin
            n_checks++;
            $display("FAIL wait_cycle: got cycle %0d, want %0d", cyc, k);
        end
    endtask

    task automatic load_directed_rom();
        rom[0][0] = 8'h11;
        rom[0][1] = 8'h22;
        rom[0][2] = 8'h33;
        rom[0][3] = 8'h44;
        rom[1][0] = 8'h5A;
        rom[1][1] = 8'h00;
        rom[1][2] = 8'h00;
        rom[1][3] = 8'h00;
    endtask

    task automatic restart();
        reset = 1'b1;
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
    endtask

    initial begin
        load_directed_rom();
        reset   = 1'b1;
        dn_wait = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("lit_rst_dn_go", 0, 16'(dn_go_a[0]), 16'h0000);
        chk("lit_rst_exec_addr", 1, exec_addr_a[1], 16'hBEEF);
        reset = 1'b0;

        // Free-running load of 11,22,33,44 and of the single byte 5A.
        wait_cycle(1);
        chk("lit_c1_rom_addr", 0, rom_addr_a[0], 16'h0000);
        chk("lit_c1_dn_go", 0, 16'(dn_go_a[0]), 16'h0001);
        wait_cycle(2);
        chk("lit_c2_dn_wr", 0, 16'(dn_wr_a[0]), 16'h0001);
        chk("lit_c2_dn_data", 0, 16'(dn_data_a[0]), 16'h0011);
        chk("lit_c2_dn_data", 1, 16'(dn_data_a[1]), 16'h005A);
        wait_cycle(3);
        chk("lit_c3_exec", 1, 16'(exec_en_a[1]), CkEn ? 16'h0000 : 16'h0001);
        chk("lit_c3_load_err", 1, 16'(load_err_a[1]), CkEn ? 16'h0001 : 16'h0000);
        wait_cycle(8);
        chk("lit_c8_dn_addr", 0, dn_addr_a[0], 16'h0003);
        chk("lit_c8_dn_data", 0, 16'(dn_data_a[0]), 16'h0044);
        wait_cycle(9);
        chk("lit_c9_exec", 0, 16'(exec_en_a[0]), 16'h0001);
        chk("lit_c9_dn_go", 0, 16'(dn_go_a[0]), 16'h0000);
        chk("lit_c9_load_err", 0, 16'(load_err_a[0]), 16'h0000);
        wait_cycle(10);
        chk("lit_c10_exec", 0, 16'(exec_en_a[0]), 16'h0000);
        repeat (100) @(negedge clk_sys);

        // Back-pressure on the second byte during cycles 4..6.
        restart();
        wait_cycle(4);
        dn_wait = 1'b1;
        wait_cycle(7);
        dn_wait = 1'b0;
        chk("lit_stall_dn_wr", 0, 16'(dn_wr_a[0]), 16'h0001);
        chk("lit_stall_dn_addr", 0, dn_addr_a[0], 16'h0001);
        chk("lit_stall_dn_data", 0, 16'(dn_data_a[0]), 16'h0022);
        wait_cycle(11);
        chk("lit_stall_c11_exec", 0, 16'(exec_en_a[0]), 16'h0000);
        wait_cycle(12);
        chk("lit_stall_c12_exec", 0, 16'(exec_en_a[0]), 16'h0001);
        repeat (5) @(negedge clk_sys);

        // Reset mid-load, then a full restart from address 0.
        restart();
        wait_cycle(5);
        reset = 1'b1;
        @(negedge clk_sys);
        chk("lit_abort_dn_wr", 0, 16'(dn_wr_a[0]), 16'h0000);
        chk("lit_abort_dn_addr", 0, dn_addr_a[0], 16'h0000);
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        wait_cycle(2);
        chk("lit_restart_dn_addr", 0, dn_addr_a[0], 16'h0000);
        chk("lit_restart_dn_data", 0, 16'(dn_data_a[0]), 16'h0011);
        wait_cycle(9);
        chk("lit_restart_exec", 0, 16'(exec_en_a[0]), 16'h0001);

        // Random ROM contents, random stalls and occasional reset pulses.
        for (int it = 0; it < 25; it++) begin
            reset = 1'b1;
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 4; j++) begin
                    rom[i][j] = 8'($urandom_range(0, 255));
                end
            end
            if (it == 0) begin
                load_directed_rom();
            end
            repeat (2) @(negedge clk_sys);
            reset = 1'b0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk_sys);
                dn_wait = ($urandom_range(0, 2) == 0);
                reset   = ($urandom_range(0, 79) == 0);
            end
            dn_wait = 1'b0;
        end
        reset = 1'b0;
        repeat (3) @(negedge clk_sys);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
